// File: rtl/morse_tx_encoder_if.sv
// Character handshake and key-line outputs of the Morse transmitter.
// The source drives char_valid/char_in; the encoder drives the rest.
interface morse_tx_encoder_if;
  logic       char_valid;
  logic [7:0] char_in;
  logic       char_ready;
  logic       key_out;
  logic [1:0] sym_out;
  logic       busy;
  logic       char_err;

  modport master (
    output char_valid,
    output char_in,
    input  char_ready,
    input  key_out,
    input  sym_out,
    input  busy,
    input  char_err
  );

  modport slave (
    input  char_valid,
    input  char_in,
    output char_ready,
    output key_out,
    output sym_out,
    output busy,
    output char_err
  );
endinterface

// File: rtl/morse_tx_encoder.sv
// Morse transmitter: takes one ASCII character per handshake and keys
// it out as dots/dashes with unit-based mark and gap timing.
module morse_tx_encoder #(
  parameter int DOT_TICKS = 12500000,
  parameter int CNT_W     = 30
) (
  input  logic              clock,
  input  logic              reset,
  morse_tx_encoder_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MARK     = 3'd1;
  localparam logic [2:0] S_SYM_GAP  = 3'd2;
  localparam logic [2:0] S_CHAR_GAP = 3'd3;
  localparam logic [2:0] S_WORD_GAP = 3'd4;

  // Last count value of a 1-, 3- and 7-unit interval.
  localparam logic [CNT_W-1:0] L_U1 = CNT_W'(DOT_TICKS - 1);
  localparam logic [CNT_W-1:0] L_U3 = CNT_W'(3 * DOT_TICKS - 1);
  localparam logic [CNT_W-1:0] L_U7 = CNT_W'(7 * DOT_TICKS - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [4:0]       r_pat;
  logic [2:0]       r_left;
  logic             r_key;
  logic [1:0]       r_sym;
  logic             r_busy;
  logic             r_ready;
  logic             r_err;

  logic [7:0]       w_up;
  logic             w_ok;
  logic             w_space;
  logic [2:0]       w_len;
  logic [4:0]       w_pat;
  logic             w_acc;
  logic [CNT_W-1:0] w_dur;
  logic             w_done;
  logic [2:0]       w_ns;
  logic             w_bit;

  assign w_acc = bus.char_valid & r_ready;

  // Fold lower case onto upper case before the code lookup.
  always_comb begin
    w_up = bus.char_in;
    if (bus.char_in >= 8'h61 && bus.char_in <= 8'h7A)
      w_up = bus.char_in - 8'h20;
  end

  // Code ROM: length and left-aligned pattern, bit 4 sent first, 1 = dash.
  always_comb begin
    w_ok    = 1'b0;
    w_space = 1'b0;
    w_len   = 3'd0;
    w_pat   = 5'b00000;
    case (w_up)
      8'h20: w_space = 1'b1;
      8'h41: {w_ok, w_len, w_pat} = {1'b1, 3'd2, 5'b01000};
      8'h42: {w_ok, w_len, w_pat} = {1'b1, 3'd4, 5'b10000};
      8'h43: {w_ok, w_len, w_pat} = {1'b1, 3'd4, 5'b10100};
      8'h44: {w_ok, w_len, w_pat} = {1'b1, 3'd3, 5'b10000};
      8'h45: {w_ok, w_len, w_pat} = {1'b1, 3'd1, 5'b00000};
      8'h46: {w_ok, w_len, w_pat} = {1'b1, 3'd4, 5'b00100};
      8'h47: {w_ok, w_len, w_pat} = {1'b1, 3'd3, 5'b11000};
      8'h48: {w_ok, w_len, w_pat} = {1'b1, 3'd4, 5'b00000};
      8'h49: {w_ok, w_len, w_pat} = {1'b1, 3'd2, 5'b00000};
      8'h4A: {w_ok, w_len, w_pat} = {1'b1, 3'd4, 5'b01110};
      8'h4B: {w_ok, w_len, w_pat} = {1'b1, 3'd3, 5'b10100};
      8'h4C: {w_ok, w_len, w_pat} = {1'b1, 3'd4, 5'b01000};
      8'h4D: {w_ok, w_len, w_pat} = {1'b1, 3'd2, 5'b11000};
      8'h4E: {w_ok, w_len, w_pat} = {1'b1, 3'd2, 5'b10000};
      8'h4F: {w_ok, w_len, w_pat} = {1'b1, 3'd3, 5'b11100};
      8'h50: {w_ok, w_len, w_pat} = {1'b1, 3'd4, 5'b01100};
      8'h51: {w_ok, w_len, w_pat} = {1'b1, 3'd4, 5'b11010};
      8'h52: {w_ok, w_len, w_pat} = {1'b1, 3'd3, 5'b01000};
      8'h53: {w_ok, w_len, w_pat} = {1'b1, 3'd3, 5'b00000};
      8'h54: {w_ok, w_len, w_pat} = {1'b1, 3'd1, 5'b10000};
      8'h55: {w_ok, w_len, w_pat} = {1'b1, 3'd3, 5'b00100};
      8'h56: {w_ok, w_len, w_pat} = {1'b1, 3'd4, 5'b00010};
      8'h57: {w_ok, w_len, w_pat} = {1'b1, 3'd3, 5'b01100};
      8'h58: {w_ok, w_len, w_pat} = {1'b1, 3'd4, 5'b10010};
      8'h59: {w_ok, w_len, w_pat} = {1'b1, 3'd4, 5'b10110};
      8'h5A: {w_ok, w_len, w_pat} = {1'b1, 3'd4, 5'b11000};
      8'h30: {w_ok, w_len, w_pat} = {1'b1, 3'd5, 5'b11111};
      8'h31: {w_ok, w_len, w_pat} = {1'b1, 3'd5, 5'b01111};
      8'h32: {w_ok, w_len, w_pat} = {1'b1, 3'd5, 5'b00111};
      8'h33: {w_ok, w_len, w_pat} = {1'b1, 3'd5, 5'b00011};
      8'h34: {w_ok, w_len, w_pat} = {1'b1, 3'd5, 5'b00001};
      8'h35: {w_ok, w_len, w_pat} = {1'b1, 3'd5, 5'b00000};
      8'h36: {w_ok, w_len, w_pat} = {1'b1, 3'd5, 5'b10000};
      8'h37: {w_ok, w_len, w_pat} = {1'b1, 3'd5, 5'b11000};
      8'h38: {w_ok, w_len, w_pat} = {1'b1, 3'd5, 5'b11100};
      8'h39: {w_ok, w_len, w_pat} = {1'b1, 3'd5, 5'b11110};
      default: begin
        w_ok    = 1'b0;
        w_space = 1'b0;
      end
    endcase
  end

  // Length of the interval the current state times out.
  always_comb begin
    w_dur = '0;
    case (r_state)
      S_MARK:     w_dur = r_pat[4] ? L_U3 : L_U1;
      S_SYM_GAP:  w_dur = L_U1;
      S_CHAR_GAP: w_dur = L_U3;
      S_WORD_GAP: w_dur = L_U7;
      default:    w_dur = '0;
    endcase
  end

  assign w_done = (r_cnt == w_dur);

  // Next-state logic.
  always_comb begin
    w_ns = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc && w_ok)
          w_ns = S_MARK;
        else if (w_acc && w_space)
          w_ns = S_WORD_GAP;
      end
      S_MARK: begin
        if (w_done)
          w_ns = (r_left != 3'd0) ? S_SYM_GAP : S_CHAR_GAP;
      end
      S_SYM_GAP: begin
        if (w_done)
          w_ns = S_MARK;
      end
      S_CHAR_GAP, S_WORD_GAP: begin
        if (w_done)
          w_ns = S_IDLE;
      end
      default: w_ns = S_IDLE;
    endcase
  end

  // A fresh character keys its first symbol straight from the ROM.
  assign w_bit = (r_state == S_IDLE) ? w_pat[4] : r_pat[4];

  // State register and unit counter; counter restarts on every state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_ns;
      if (w_ns != r_state || r_state == S_IDLE)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Symbol shifter: loaded on accept, advanced as each mark ends.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pat  <= 5'b00000;
      r_left <= 3'd0;
    end else if (r_state == S_IDLE && w_acc && w_ok) begin
      r_pat  <= w_pat;
      r_left <= w_len - 3'd1;
    end else if (r_state == S_MARK && w_done && r_left != 3'd0) begin
      r_pat  <= {r_pat[3:0], 1'b0};
      r_left <= r_left - 3'd1;
    end
  end

  // Registered outputs derived from the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_key   <= 1'b0;
      r_sym   <= 2'b00;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_key   <= (w_ns == S_MARK);
      r_sym   <= (w_ns == S_MARK) ? {1'b1, w_bit} : 2'b00;
      r_busy  <= (w_ns != S_IDLE);
      r_ready <= (w_ns == S_IDLE);
      r_err   <= w_acc & ~w_ok & ~w_space;
    end
  end

  assign bus.key_out    = r_key;
  assign bus.sym_out    = r_sym;
  assign bus.busy       = r_busy;
  assign bus.char_ready = r_ready;
  assign bus.char_err   = r_err;

endmodule
